// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial wide add/subtract sequencer driving a shared 4-bit addsub datapath.
// Operands are latched on start and processed LSB nibble first, with carry/borrow chained between nibbles.
module addsub_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co_bo,
  output logic [3:0]             dp_a,
  output logic [3:0]             dp_b,
  output logic                   dp_xin,
  output logic                   dp_op,
  input  logic [3:0]             dp_sd,
  input  logic                   dp_cobo
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             chain_q, chain_d;
  logic [W-1:0]     a_lat_q, a_lat_d;
  logic [W-1:0]     b_lat_q, b_lat_d;
  logic             op_lat_q, op_lat_d;
  logic [W-1:0]     result_q, result_d;
  logic             co_bo_q, co_bo_d;
  logic             accept;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      op_lat_q <= 1'b0;
      result_q <= '0;
      co_bo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      op_lat_q <= op_lat_d;
      result_q <= result_d;
      co_bo_q  <= co_bo_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    op_lat_d = op_lat_q;
    result_d = result_q;
    co_bo_d  = co_bo_q;
    accept   = start && (state_q != RUN);

    case (state_q)
      RUN: begin
        result_d[4*idx_q +: 4] = dp_sd;
        chain_d                = dp_cobo;
        idx_d                  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          co_bo_d = dp_cobo;
          idx_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in IDLE or DONE begins a fresh operation and clears the previous result
    if (accept) begin
      state_d  = RUN;
      a_lat_d  = a_in;
      b_lat_d  = b_in;
      op_lat_d = op;
      idx_d    = '0;
      chain_d  = 1'b0;
      result_d = '0;
      co_bo_d  = 1'b0;
    end
  end

  // Datapath operands are only presented while sequencing
  always_comb begin
    dp_a   = 4'd0;
    dp_b   = 4'd0;
    dp_xin = 1'b0;
    dp_op  = op_lat_q;
    if (state_q == RUN) begin
      dp_a   = a_lat_q[4*idx_q +: 4];
      dp_b   = b_lat_q[4*idx_q +: 4];
      dp_xin = chain_q;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign co_bo  = co_bo_q;

endmodule
